// File: rtl/sprite_pos_regs_if.sv
// CPU memory-bus bundle for the sprite position register block.
// The CPU side drives address/strobes/data; the register block returns registered read data.
interface sprite_pos_regs_if #(
  parameter int ADDR_BITS = 16
);
  logic [ADDR_BITS-1:0] addr;
  logic                 we;
  logic                 re;
  logic [15:0]          wdata;
  logic [15:0]          rdata;
  logic                 rvalid;

  modport master (output addr, we, re, wdata, input rdata, rvalid);
  modport slave  (input addr, we, re, wdata, output rdata, rvalid);
endinterface

// File: rtl/sprite_pos_regs.sv
// Shadowed sprite position registers: CPU stores land in shadow copies and are committed
// to the vga-facing outputs once per frame on the falling edge of v_sync, avoiding tearing.
module sprite_pos_regs #(
  parameter int MX        = 6000,
  parameter int MY        = 6004,
  parameter int P1X       = 6008,
  parameter int P1Y       = 6012,
  parameter int P2X       = 6016,
  parameter int P2Y       = 6020,
  parameter int STAT      = 6024,
  parameter int ADDR_BITS = 16
) (
  input  logic                    clk_50MHz,
  input  logic                    clear,
  sprite_pos_regs_if.slave        bus,
  input  logic                    v_sync,
  output logic [15:0]             mx,
  output logic [15:0]             my,
  output logic [15:0]             p1x,
  output logic [15:0]             p1y,
  output logic [15:0]             p2x,
  output logic [15:0]             p2y,
  output logic                    frame_tick
);

  localparam logic [ADDR_BITS-1:0] POS_ADDR [6] = '{
    ADDR_BITS'(MX),  ADDR_BITS'(MY),  ADDR_BITS'(P1X),
    ADDR_BITS'(P1Y), ADDR_BITS'(P2X), ADDR_BITS'(P2Y)
  };
  localparam logic [ADDR_BITS-1:0] STAT_ADDR = ADDR_BITS'(STAT);

  logic [15:0] r_shadow [6];
  logic [15:0] r_active [6];
  logic [15:0] r_frameCnt;
  logic        r_dirty;
  logic        r_vsQ;

  logic [5:0]  w_wrSel;
  logic [15:0] w_rdData;
  logic        w_vsFall;

  assign w_vsFall = r_vsQ & ~v_sync;

  // Exact full-width decode; anything else (including unaligned) reads as zero.
  always_comb begin
    w_wrSel  = '0;
    w_rdData = '0;
    for (int i = 0; i < 6; i++) begin
      if (bus.addr == POS_ADDR[i]) begin
        w_wrSel[i] = bus.we;
        w_rdData   = r_shadow[i];
      end
    end
    if (bus.addr == STAT_ADDR) begin
      w_rdData = {r_dirty, r_frameCnt[14:0]};
    end
  end

  // Commit copies the pre-write shadow; a coincident write re-arms dirty for next frame.
  always_ff @(posedge clk_50MHz) begin
    if (clear) begin
      for (int i = 0; i < 6; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_frameCnt <= '0;
      r_dirty    <= 1'b0;
      r_vsQ      <= 1'b1;
      frame_tick <= 1'b0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      r_vsQ      <= v_sync;
      frame_tick <= w_vsFall;
      bus.rvalid <= bus.re;
      if (bus.re) begin
        bus.rdata <= w_rdData;
      end
      if (w_vsFall) begin
        r_frameCnt <= r_frameCnt + 16'd1;
        r_dirty    <= 1'b0;
      end
      for (int i = 0; i < 6; i++) begin
        if (w_vsFall && r_dirty) begin
          r_active[i] <= r_shadow[i];
        end
        if (w_wrSel[i]) begin
          r_shadow[i] <= bus.wdata;
        end
      end
      if (|w_wrSel) begin
        r_dirty <= 1'b1;
      end
    end
  end

  assign mx  = r_active[0];
  assign my  = r_active[1];
  assign p1x = r_active[2];
  assign p1y = r_active[3];
  assign p2x = r_active[4];
  assign p2y = r_active[5];

endmodule
